// File: rtl/server_task_if.sv
// Task-dispatch handshake bundle: assignment channel toward the servers and
// completion (done) channel back to the dispatcher.
interface server_task_if;
   logic       assign_valid;
   logic [1:0] assign_server;
   logic       assign_ready;
   logic       done_valid;
   logic [1:0] done_server;
   logic       done_ready;

   modport master (
      output assign_valid, assign_server, done_ready,
      input  assign_ready, done_valid, done_server
   );

   modport slave (
      input  assign_valid, assign_server, done_ready,
      output assign_ready, done_valid, done_server
   );
endinterface

// File: rtl/server_task_sink.sv
// Server-side sink for dispatched tasks: per-server pending counters, a small
// IDLE/BUSY/HOLD service FSM per server and a single shared done-report slot.
module server_task_sink #(
   parameter int SERVICE_CYCLES = 4,
   parameter int MAX_PENDING    = 15,
   parameter int THRESHOLD      = 3
) (
   input  logic              clk,
   input  logic              reset,
   server_task_if.slave      bus,
   output logic [3:0]        server1_pending,
   output logic [3:0]        server2_pending,
   output logic [3:0]        server3_pending,
   output logic              trigger,
   output logic              overload
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} srv_state_t;

   srv_state_t state      [3];
   srv_state_t state_next [3];
   logic [3:0] timer      [3];
   logic [3:0] timer_next [3];
   logic [3:0] pending    [3];

   logic [2:0] in_hold;
   logic [2:0] grant;
   logic [2:0] accept_hit;
   logic       load;
   logic [1:0] winner_code;
   logic       ready;
   logic       done_valid_q;
   logic [1:0] done_server_q;

   // Back-pressure only when the addressed server is full; illegal target 00 is swallowed.
   always_comb begin
      ready = 1'b1;
      case (bus.assign_server)
         2'b01:   ready = (pending[0] != 4'(MAX_PENDING));
         2'b10:   ready = (pending[1] != 4'(MAX_PENDING));
         2'b11:   ready = (pending[2] != 4'(MAX_PENDING));
         default: ready = 1'b1;
      endcase
   end

   always_comb begin
      accept_hit = '0;
      for (int i = 0; i < 3; i++)
         accept_hit[i] = bus.assign_valid && ready && (bus.assign_server == 2'(i + 1));
   end

   // FSM outputs plus the fixed-priority arbiter for the done slot.
   always_comb begin
      for (int i = 0; i < 3; i++)
         in_hold[i] = (state[i] == HOLD);
      load        = (!done_valid_q || bus.done_ready) && (|in_hold);
      grant       = '0;
      winner_code = 2'b00;
      if (load) begin
         if (in_hold[0]) begin
            grant       = 3'b001;
            winner_code = 2'b01;
         end else if (in_hold[1]) begin
            grant       = 3'b010;
            winner_code = 2'b10;
         end else begin
            grant       = 3'b100;
            winner_code = 2'b11;
         end
      end
   end

   // Next-state and timer logic for each server.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         state_next[i] = state[i];
         timer_next[i] = timer[i];
         case (state[i])
            IDLE: begin
               if (pending[i] != 4'd0) begin
                  state_next[i] = BUSY;
                  timer_next[i] = 4'(SERVICE_CYCLES - 1);
               end
            end
            BUSY: begin
               if (timer[i] != 4'd0)
                  timer_next[i] = timer[i] - 4'd1;
               else
                  state_next[i] = HOLD;
            end
            HOLD: begin
               if (grant[i])
                  state_next[i] = IDLE;
            end
            default: state_next[i] = IDLE;
         endcase
      end
   end

   // Accept and grant on one server in the same cycle cancel out in the counter.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            state[i]   <= IDLE;
            timer[i]   <= 4'd0;
            pending[i] <= 4'd0;
         end else begin
            state[i]   <= state_next[i];
            timer[i]   <= timer_next[i];
            pending[i] <= pending[i] + {3'b000, accept_hit[i]} - {3'b000, grant[i]};
         end
      end
   end

   // Done slot keeps its contents stable until the consumer takes them.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_valid_q  <= 1'b0;
         done_server_q <= 2'b00;
      end else if (load) begin
         done_valid_q  <= 1'b1;
         done_server_q <= winner_code;
      end else if (bus.done_ready) begin
         done_valid_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trigger  <= 1'b0;
         overload <= 1'b0;
      end else begin
         trigger  <= (pending[0] >= 4'(THRESHOLD)) || (pending[1] >= 4'(THRESHOLD)) ||
                     (pending[2] >= 4'(THRESHOLD));
         overload <= (pending[0] >= 4'(THRESHOLD)) && (pending[1] >= 4'(THRESHOLD)) &&
                     (pending[2] >= 4'(THRESHOLD));
      end
   end

   assign bus.assign_ready = ready;
   assign bus.done_valid   = done_valid_q;
   assign bus.done_server  = done_server_q;
   assign server1_pending  = pending[0];
   assign server2_pending  = pending[1];
   assign server3_pending  = pending[2];

endmodule

// File: tb/tb_server_task_sink.sv
// Scenario bench for server_task_sink: expected completions go into a scoreboard
// queue when beats are driven and are retired as done reports appear.
module tb_server_task_sink;

   logic       clk;
   logic       reset;
   logic [3:0] server1_pending;
   logic [3:0] server2_pending;
   logic [3:0] server3_pending;
   logic       trigger;
   logic       overload;

   int         errors;
   int         checks;
   logic [1:0] sb [$];

   server_task_if bus ();

   server_task_sink #(.SERVICE_CYCLES(4), .MAX_PENDING(15), .THRESHOLD(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .server1_pending (server1_pending),
      .server2_pending (server2_pending),
      .server3_pending (server3_pending),
      .trigger         (trigger),
      .overload        (overload)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] pend(input logic [1:0] s);
      case (s)
         2'b01:   return server1_pending;
         2'b10:   return server2_pending;
         2'b11:   return server3_pending;
         default: return 4'hx;
      endcase
   endfunction

   // Retire scoreboard entries against done reports, consumer always ready.
   task automatic drain(input bit ordered, input int budget);
      int cycles;
      bit found;
      cycles = 0;
      bus.done_ready = 1'b1;
      while (sb.size() != 0 && cycles < budget) begin
         if (bus.done_valid === 1'b1) begin
            checks++;
            if (ordered) begin
               if (bus.done_server !== sb[0]) begin
                  errors++;
                  $display("[TB] FAIL done_order: got %b expected %b", bus.done_server, sb[0]);
               end
               void'(sb.pop_front());
            end else begin
               found = 1'b0;
               for (int k = 0; k < sb.size(); k++) begin
                  if (!found && sb[k] === bus.done_server) begin
                     sb.delete(k);
                     found = 1'b1;
                  end
               end
               if (!found) begin
                  errors++;
                  $display("[TB] FAIL done_unexpected: got %b, not outstanding", bus.done_server);
               end
            end
         end
         tick();
         cycles++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: %0d reports outstanding, expected 0", sb.size());
         sb.delete();
      end
      checks++;
      if (bus.done_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL slot_clear: done_valid=%b expected 0", bus.done_valid);
      end
   endtask

   // One beat into an idle sink; done report must appear exactly SERVICE_CYCLES+2 edges later.
   task automatic check_latency(input logic [1:0] srv);
      bus.done_ready    = 1'b1;
      bus.assign_valid  = 1'b1;
      bus.assign_server = srv;
      tick();
      bus.assign_valid  = 1'b0;
      sb.push_back(srv);
      checks++;
      if (pend(srv) !== 4'd1) begin
         errors++;
         $display("[TB] FAIL lat_pending_inc: got %0d expected 1", pend(srv));
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (bus.done_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lat_early_done: edge %0d done_valid=%b expected 0", k, bus.done_valid);
         end
      end
      tick();
      checks++;
      if (bus.done_valid !== 1'b1 || bus.done_server !== sb[0]) begin
         errors++;
         $display("[TB] FAIL lat_done: got v=%b s=%b expected v=1 s=%b",
                  bus.done_valid, bus.done_server, sb[0]);
      end
      void'(sb.pop_front());
      checks++;
      if (pend(srv) !== 4'd0) begin
         errors++;
         $display("[TB] FAIL lat_pending_dec: got %0d expected 0", pend(srv));
      end
      tick();
      checks++;
      if (bus.done_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lat_one_cycle: done_valid=%b expected 0", bus.done_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if ({server1_pending, server2_pending, server3_pending} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_pending: got %h expected 000",
                  {server1_pending, server2_pending, server3_pending});
      end
      checks++;
      if ({bus.done_valid, bus.done_server, trigger, overload} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b expected 00000",
                  {bus.done_valid, bus.done_server, trigger, overload});
      end
      checks++;
      if (bus.assign_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b expected 1", bus.assign_ready);
      end
   endtask

   task automatic test_single();
      check_latency(2'b10);
   endtask

   // server3 reaches HOLD first and owns the slot; server1 waits behind it.
   task automatic test_hold_arbitration();
      bus.done_ready    = 1'b0;
      bus.assign_valid  = 1'b1;
      bus.assign_server = 2'b11;
      tick();
      bus.assign_server = 2'b01;
      tick();
      bus.assign_valid  = 1'b0;
      sb.push_back(2'b11);
      sb.push_back(2'b01);
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (bus.done_valid !== 1'b1 || bus.done_server !== 2'b11) begin
         errors++;
         $display("[TB] FAIL hold_first: got v=%b s=%b expected v=1 s=11", bus.done_valid, bus.done_server);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (bus.done_valid !== 1'b1 || bus.done_server !== 2'b11 ||
             server1_pending !== 4'd1 || server3_pending !== 4'd0) begin
            errors++;
            $display("[TB] FAIL hold_stable: got v=%b s=%b p1=%0d p3=%0d expected v=1 s=11 p1=1 p3=0",
                     bus.done_valid, bus.done_server, server1_pending, server3_pending);
         end
      end
      drain(1'b1, 50);
   endtask

   // 17 back-to-back beats to server1 with the slot blocked after one completion.
   task automatic test_saturation();
      bus.done_ready = 1'b0;
      for (int b = 0; b < 17; b++) begin
         bus.assign_valid  = 1'b1;
         bus.assign_server = 2'b01;
         #1;
         checks++;
         if (bus.assign_ready !== (b < 16)) begin
            errors++;
            $display("[TB] FAIL sat_ready: beat %0d got %b expected %b", b, bus.assign_ready, (b < 16));
         end
         tick();
      end
      bus.assign_valid = 1'b0;
      for (int b = 0; b < 16; b++) sb.push_back(2'b01);
      checks++;
      if (server1_pending !== 4'd15) begin
         errors++;
         $display("[TB] FAIL sat_count: got %0d expected 15", server1_pending);
      end
      checks++;
      if (trigger !== 1'b1 || overload !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sat_flags: got t=%b o=%b expected t=1 o=0", trigger, overload);
      end
      bus.assign_server = 2'b10;
      #1;
      checks++;
      if (bus.assign_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_other_ready: got %b expected 1", bus.assign_ready);
      end
      drain(1'b1, 300);
   endtask

   // Fill 3/3/3 with the slot blocked; the 7th beat collides with server1's grant.
   task automatic test_threshold_and_collision();
      logic [1:0] seq [10];
      seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
      bus.done_ready = 1'b0;
      for (int e = 0; e < 10; e++) begin
         bus.assign_valid  = 1'b1;
         bus.assign_server = seq[e];
         tick();
         sb.push_back(seq[e]);
         if (e == 2) begin
            checks++;
            if (server1_pending !== 4'd3 || trigger !== 1'b0) begin
               errors++;
               $display("[TB] FAIL thr_lag: got p1=%0d t=%b expected p1=3 t=0", server1_pending, trigger);
            end
         end
         if (e == 3) begin
            checks++;
            if (trigger !== 1'b1 || overload !== 1'b0) begin
               errors++;
               $display("[TB] FAIL thr_trigger: got t=%b o=%b expected t=1 o=0", trigger, overload);
            end
         end
         if (e == 6) begin
            checks++;
            if (server1_pending !== 4'd3 || bus.done_valid !== 1'b1 || bus.done_server !== 2'b01) begin
               errors++;
               $display("[TB] FAIL collide: got p1=%0d v=%b s=%b expected p1=3 v=1 s=01",
                        server1_pending, bus.done_valid, bus.done_server);
            end
         end
         if (e == 9) begin
            checks++;
            if ({server1_pending, server2_pending, server3_pending} !== 12'h333 || overload !== 1'b0) begin
               errors++;
               $display("[TB] FAIL thr_full: got %h o=%b expected 333 o=0",
                        {server1_pending, server2_pending, server3_pending}, overload);
            end
         end
      end
      bus.assign_server = 2'b00;
      #1;
      checks++;
      if (bus.assign_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL null_ready: got %b expected 1", bus.assign_ready);
      end
      tick();
      bus.assign_valid = 1'b0;
      checks++;
      if ({server1_pending, server2_pending, server3_pending} !== 12'h333 ||
          overload !== 1'b1 || trigger !== 1'b1) begin
         errors++;
         $display("[TB] FAIL null_beat: got %h t=%b o=%b expected 333 t=1 o=1",
                  {server1_pending, server2_pending, server3_pending}, trigger, overload);
      end
      drain(1'b0, 300);
   endtask

   task automatic test_reset_midflight();
      bus.done_ready    = 1'b1;
      bus.assign_valid  = 1'b1;
      bus.assign_server = 2'b01;
      tick();
      bus.assign_server = 2'b10;
      tick();
      bus.assign_valid  = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      checks++;
      if ({server1_pending, server2_pending, server3_pending, bus.done_valid,
           bus.done_server, trigger, overload} !== 17'b0) begin
         errors++;
         $display("[TB] FAIL midreset: got p=%h v=%b s=%b t=%b o=%b expected all 0",
                  {server1_pending, server2_pending, server3_pending},
                  bus.done_valid, bus.done_server, trigger, overload);
      end
      check_latency(2'b11);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      bus.assign_valid  = 1'b0;
      bus.assign_server = 2'b00;
      bus.done_ready    = 1'b1;
      test_reset();
      test_single();
      test_hold_arbitration();
      test_saturation();
      test_threshold_and_collision();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
